// File: rtl/rf_ws_if.sv
// Bundle between the write sequencer and its neighbours: pipeline writeback (A),
// long-latency result queue (B), register-file write port and hazard status.
interface rf_ws_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             a_valid;
   logic [4:0]       a_rd;
   logic [31:0]      a_data;
   logic             a_stall;
   logic             b_valid;
   logic [4:0]       b_rd;
   logic [31:0]      b_data;
   logic             b_ready;
   logic [4:0]       rf_rw;
   logic [31:0]      rf_pw;
   logic             rf_le;
   logic [31:0]      busy_mask;
   logic [CNT_W-1:0] fifo_count;

   modport master (
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output a_stall, b_ready, rf_rw, rf_pw, rf_le, busy_mask, fifo_count
   );

   modport slave (
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  a_stall, b_ready, rf_rw, rf_pw, rf_le, busy_mask, fifo_count
   );
endinterface

// File: rtl/rf_write_sequencer.sv
// Merges in-order writeback (A, fixed priority) with queued long-latency results (B)
// onto the single register-file write port; exports a busy mask for pending B writes.
module rf_write_sequencer #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic     clk,
   input logic     rst,
   rf_ws_if.master bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned STV_W = 4;

   logic [4:0]       rd_mem_q   [DEPTH];
   logic [31:0]      data_mem_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [STV_W-1:0] starve_q, starve_d;
   logic             rf_le_q, rf_le_d;
   logic             b_src_q, b_src_d;
   logic [4:0]       rf_rw_q, rf_rw_d;
   logic [31:0]      rf_pw_q, rf_pw_d;

   logic             a_sel_c, empty_c, pop_c, push_c, ready_c;
   logic [31:0]      busy_c;

   // Arbitration and handshake: A with a real destination always wins
   always_comb begin
      empty_c = (count_q == '0);
      a_sel_c = bus.a_valid && (bus.a_rd != 5'd0);
      pop_c   = !a_sel_c && !empty_c;
      ready_c = !rst && (count_q < CNT_W'(DEPTH));
      push_c  = bus.b_valid && ready_c && (bus.b_rd != 5'd0);
   end

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      vld_d    = vld_q;
      starve_d = starve_q;
      rf_le_d  = 1'b0;
      b_src_d  = 1'b0;
      rf_rw_d  = rf_rw_q;
      rf_pw_d  = rf_pw_q;

      if (a_sel_c) begin
         rf_le_d = 1'b1;
         rf_rw_d = bus.a_rd;
         rf_pw_d = bus.a_data;
      end else if (pop_c) begin
         rf_le_d = 1'b1;
         b_src_d = 1'b1;
         rf_rw_d = rd_mem_q[head_q];
         rf_pw_d = data_mem_q[head_q];
      end

      if (pop_c) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PTR_W'(1);
      end
      if (push_c) begin
         vld_d[tail_q] = 1'b1;
         tail_d        = tail_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
         count_d = count_q - CNT_W'(1);
      end

      // Counts consecutive A wins while B waits; saturates so a_stall holds
      if (empty_c || pop_c) begin
         starve_d = '0;
      end else if (a_sel_c && (starve_q != STV_W'(STARVE_LIMIT))) begin
         starve_d = starve_q + STV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         vld_q    <= '0;
         starve_q <= '0;
         rf_le_q  <= 1'b0;
         b_src_q  <= 1'b0;
         rf_rw_q  <= 5'd0;
         rf_pw_q  <= 32'd0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         vld_q    <= vld_d;
         starve_q <= starve_d;
         rf_le_q  <= rf_le_d;
         b_src_q  <= b_src_d;
         rf_rw_q  <= rf_rw_d;
         rf_pw_q  <= rf_pw_d;
      end
   end

   // Payload storage needs no reset; validity is tracked by vld_q
   always_ff @(posedge clk) begin
      if (push_c) begin
         rd_mem_q[tail_q]   <= bus.b_rd;
         data_mem_q[tail_q] <= bus.b_data;
      end
   end

   always_comb begin
      busy_c = 32'd0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld_q[i]) begin
            busy_c[rd_mem_q[i]] = 1'b1;
         end
      end
      if (rf_le_q && b_src_q) begin
         busy_c[rf_rw_q] = 1'b1;
      end
      busy_c[0] = 1'b0;
   end

   assign bus.b_ready    = ready_c;
   assign bus.a_stall    = (starve_q == STV_W'(STARVE_LIMIT));
   assign bus.rf_le      = rf_le_q;
   assign bus.rf_rw      = rf_rw_q;
   assign bus.rf_pw      = rf_pw_q;
   assign bus.busy_mask  = busy_c;
   assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_rf_write_sequencer.sv
// Bench for rf_write_sequencer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rf_write_sequencer;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LIMIT = 8;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   rf_ws_if #(.DEPTH(DEPTH)) bus ();

   rf_write_sequencer #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   ent_t        mq[$];
   logic        m_le   = 1'b0;
   logic        m_bsrc = 1'b0;
   logic [4:0]  m_rw   = 5'd0;
   logic [31:0] m_pw   = 32'd0;
   int          m_starve = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.a_valid = 1'b0;
      bus.a_rd    = 5'd0;
      bus.a_data  = 32'd0;
      bus.b_valid = 1'b0;
      bus.b_rd    = 5'd0;
      bus.b_data  = 32'd0;
   endtask

   // Compare DUT against model, then advance model with the inputs of this cycle
   initial begin
      logic [31:0] em;
      ent_t        e;
      bit          rdy;
      forever begin
         @(negedge clk);
         em = 32'd0;
         foreach (mq[i]) em[mq[i].rd] = 1'b1;
         if (m_le && m_bsrc) em[m_rw] = 1'b1;
         em[0] = 1'b0;
         rdy = !rst && (mq.size() < DEPTH);

         chk("b_ready",    32'(bus.b_ready), 32'(rdy));
         chk("rf_le",      32'(bus.rf_le), 32'(m_le));
         chk("rf_rw",      32'(bus.rf_rw), 32'(m_rw));
         chk("rf_pw",      bus.rf_pw, m_pw);
         chk("busy_mask",  bus.busy_mask, em);
         chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
         chk("a_stall",    32'(bus.a_stall), 32'(m_starve == LIMIT));

         if (rst) begin
            mq.delete();
            m_le = 1'b0; m_bsrc = 1'b0; m_rw = 5'd0; m_pw = 32'd0; m_starve = 0;
         end else begin
            if (bus.a_valid && bus.a_rd != 5'd0) begin
               m_le = 1'b1; m_bsrc = 1'b0; m_rw = bus.a_rd; m_pw = bus.a_data;
               m_starve = (mq.size() == 0) ? 0 : ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1);
            end else if (mq.size() > 0) begin
               e = mq.pop_front();
               m_le = 1'b1; m_bsrc = 1'b1; m_rw = e.rd; m_pw = e.data;
               m_starve = 0;
            end else begin
               m_le = 1'b0; m_bsrc = 1'b0; m_starve = 0;
            end
            if (bus.b_valid && rdy && bus.b_rd != 5'd0) begin
               e.rd = bus.b_rd; e.data = bus.b_data;
               mq.push_back(e);
            end
         end
      end
   end

   initial begin
      set_idle();
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;

      // Idle after reset
      repeat (5) cyc();
      @(negedge clk);
      chk("idle_le",    32'(bus.rf_le), 32'd0);
      chk("idle_ready", 32'(bus.b_ready), 32'd1);
      chk("idle_busy",  bus.busy_mask, 32'd0);
      chk("idle_count", 32'(bus.fifo_count), 32'd0);

      // A only
      cyc();
      bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF;
      cyc();
      set_idle();
      @(negedge clk);
      chk("a_le",   32'(bus.rf_le), 32'd1);
      chk("a_rw",   32'(bus.rf_rw), 32'd5);
      chk("a_pw",   bus.rf_pw, 32'hDEADBEEF);
      chk("a_busy", bus.busy_mask, 32'd0);
      cyc();
      @(negedge clk);
      chk("a_le_off", 32'(bus.rf_le), 32'd0);

      // B queue while A holds the port, then drain in order
      cyc();
      bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = $urandom;
      for (int k = 0; k < 4; k++) begin
         bus.b_valid = 1'b1; bus.b_rd = 5'(9 + k); bus.b_data = 32'((k + 1) * 'h11);
         cyc();
      end
      bus.b_valid = 1'b0;
      @(negedge clk);
      chk("full_count", 32'(bus.fifo_count), 32'd4);
      chk("full_ready", 32'(bus.b_ready), 32'd0);
      chk("full_busy",  bus.busy_mask, 32'h1E00);
      cyc();
      bus.a_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         @(negedge clk);
         chk("drain_le", 32'(bus.rf_le), 32'd1);
         chk("drain_rw", 32'(bus.rf_rw), 32'(9 + k));
         chk("drain_pw", bus.rf_pw, 32'((k + 1) * 'h11));
      end
      cyc();
      @(negedge clk);
      chk("drain_count", 32'(bus.fifo_count), 32'd0);
      chk("drain_busy",  bus.busy_mask, 32'd0);

      // Zero-register handling on both sources
      cyc();
      bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h1234;
      @(negedge clk);
      chk("z_ready", 32'(bus.b_ready), 32'd1);
      cyc();
      bus.b_valid = 1'b0;
      @(negedge clk);
      chk("z_count", 32'(bus.fifo_count), 32'd0);
      cyc();
      bus.a_valid = 1'b1; bus.a_rd = 5'd3;
      bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'd5;
      cyc();
      bus.b_valid = 1'b0; bus.a_rd = 5'd0;
      cyc();
      set_idle();
      @(negedge clk);
      chk("z_rw", 32'(bus.rf_rw), 32'd7);
      chk("z_pw", bus.rf_pw, 32'd5);
      chk("z_le", 32'(bus.rf_le), 32'd1);

      // Starvation
      cyc();
      bus.a_valid = 1'b1; bus.a_rd = 5'd2; bus.a_data = 32'h55;
      bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'hAB;
      cyc();
      bus.b_valid = 1'b0;
      repeat (7) cyc();
      @(negedge clk);
      chk("stv_pre", 32'(bus.a_stall), 32'd0);
      cyc();
      @(negedge clk);
      chk("stv_on", 32'(bus.a_stall), 32'd1);
      chk("stv_busy", bus.busy_mask, 32'h10);
      cyc();
      bus.a_valid = 1'b0;
      cyc();
      bus.a_valid = 1'b1;
      @(negedge clk);
      chk("stv_rw",  32'(bus.rf_rw), 32'd4);
      chk("stv_pw",  bus.rf_pw, 32'hAB);
      chk("stv_off", 32'(bus.a_stall), 32'd0);
      cyc();
      set_idle();

      // Reset with entries queued
      cyc();
      bus.a_valid = 1'b1; bus.a_rd = 5'd3;
      for (int k = 0; k < 3; k++) begin
         bus.b_valid = 1'b1; bus.b_rd = 5'(20 + k); bus.b_data = $urandom;
         cyc();
      end
      bus.b_valid = 1'b0;
      @(negedge clk);
      chk("rst_pre_count", 32'(bus.fifo_count), 32'd3);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      set_idle();
      @(negedge clk);
      chk("rst_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_busy",  bus.busy_mask, 32'd0);
      chk("rst_le",    32'(bus.rf_le), 32'd0);
      repeat (4) cyc();
      @(negedge clk);
      chk("rst_no_write", 32'(bus.rf_le), 32'd0);

      // Randomized traffic with varying A pressure
      for (int n = 0; n < 3000; n++) begin
         int unsigned a_pct;
         a_pct = ((n / 300) % 2 == 0) ? 85 : 40;
         cyc();
         rst         = ($urandom_range(0, 299) == 0);
         bus.a_valid = ($urandom_range(0, 99) < a_pct);
         bus.a_rd    = 5'($urandom_range(0, 31));
         bus.a_data  = $urandom;
         bus.b_valid = ($urandom_range(0, 99) < 50);
         bus.b_rd    = 5'($urandom_range(0, 31));
         bus.b_data  = $urandom;
      end
      cyc();
      rst = 1'b0;
      set_idle();
      repeat (8) cyc();
      @(negedge clk);
      chk("end_count", 32'(bus.fifo_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rf_write_sequencer.md
Name: rf_write_sequencer

Overview:
- Write-side master for the 32x32 register file: produces the single write port (RW, PW, LE) that the register file consumes.
- Merges two result sources onto that port:
  - Source A: in-order pipeline writeback. Fixed priority, no backpressure.
  - Source B: long-latency results (mul/div, mfhi/mflo). Queued in a small FIFO with valid/ready.
- Exports a busy mask so the hazard unit stalls readers of registers that still have B results pending.

Parameters:
- DEPTH, 4, FIFO entries for source B; power of two, 2..16.
- STARVE_LIMIT, 8, consecutive A-wins cycles with B pending before a_stall is requested; 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_valid  in  1  pipeline writeback request this cycle.
- a_rd  in  5  destination register for A.
- a_data  in  32  write data for A.
- a_stall  out  1  request to pipeline to insert a writeback bubble.
- b_valid  in  1  B result offered.
- b_rd  in  5  destination register for B.
- b_data  in  32  write data for B.
- b_ready  out  1  FIFO can accept the B result.
- rf_rw  out  5  register file write address (RW).
- rf_pw  out  32  register file write data (PW).
- rf_le  out  1  register file load enable (LE).
- busy_mask  out  32  bit i = 1 when a B write to Ri is queued or in flight.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, pointers 0, starve_cnt 0.
  - rf_le=0, rf_rw=0, rf_pw=0, b_src_q=0.
  - a_stall=0, busy_mask=0, fifo_count=0.
  - b_ready forced 0 while rst is high.
  - Reset mid-operation discards all queued B entries; no write is issued.
- Source selection, per cycle n (combinational):
  - If a_valid=1 and a_rd!=0: select A.
  - Else if FIFO non-empty: select FIFO head and dequeue at edge n.
  - Else: no write.
  - a_valid with a_rd=0 counts as "A idle", so the FIFO may drain that cycle.
- Write port latency: 1 cycle. Selection in cycle n appears on rf_rw/rf_pw/rf_le during cycle n+1, and the register file latches at the n+1->n+2 edge.
- rf_le=0 whenever nothing is selected. rf_rw and rf_pw hold their last values when rf_le=0.
- b_src_q: registered flag, 1 when the current rf_* write came from the FIFO.
- Enqueue:
  - b_ready = !rst && (fifo_count < DEPTH), computed from the current count only.
  - When full, b_ready=0 even if a dequeue happens the same cycle.
  - b_valid && b_ready with b_rd!=0 pushes {b_rd, b_data} at the tail.
  - b_rd=0 completes the handshake but pushes nothing.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- B entries drain in FIFO order. A is never delayed.
- Ordering between A and B writes to the same register is not resolved here. The hazard unit must not issue an A-producing instruction whose rd has busy_mask set.
- busy_mask (combinational from state) = OR of one-hot(rd) over all valid FIFO entries, plus one-hot(rf_rw) when rf_le && b_src_q.
  - The bit clears only after the B write has been presented to the register file.
  - Bit 0 is always 0.
- Starvation counter starve_cnt (4 bits):
  - Increments when FIFO non-empty and A wins.
  - Saturates at STARVE_LIMIT.
  - Clears on any dequeue or when the FIFO is empty.
  - a_stall = (starve_cnt == STARVE_LIMIT).
  - The pipeline responds with a_valid=0 in a following cycle; that cycle the head drains and a_stall drops the next cycle.
  - If a_valid stays high, A still wins and a_stall stays asserted; no data is lost.
- fifo_count = number of valid entries, 0..DEPTH.

Test Plan:
- Reset then idle -> rf_le=0, b_ready=1, busy_mask=0, fifo_count=0 for 5 cycles.
- A only: a_valid=1, a_rd=5, a_data=32'hDEADBEEF at cycle 2 -> at cycle 3 rf_le=1, rf_rw=5, rf_pw=32'hDEADBEEF, busy_mask=0; cycle 4 rf_le=0.
- B queue and drain: with a_valid=1 (rd=3) held, push B {9,32'h11},{10,32'h22},{11,32'h33},{12,32'h44} -> b_ready=0 at count 4, busy_mask=32'h1E00; drop a_valid -> four consecutive writes R9..R12 in order; busy_mask bits clear one cycle after each write appears; count returns to 0.
- Zero register: b_rd=0 push -> handshake accepted, fifo_count unchanged; a_rd=0 with FIFO holding {7,5} -> R7 written the following cycle.
- Starvation: FIFO={4,32'hAB}, a_valid=1 for 8 cycles -> a_stall=1 after 8 A-wins; drop a_valid one cycle -> R4 written next cycle, a_stall=0, starve_cnt=0.
- Reset mid-drain: FIFO count 3, assert rst one cycle -> fifo_count=0, busy_mask=0, rf_le=0; no R-writes from the discarded entries afterwards.
